// File: rtl/aes_mixcolumns_if.sv
// rtl/aes_mixcolumns_if.sv - block handshake bundle between adjacent AES round stages
//
// Signals (directions as seen by the stage, slave modport):
//   valid            in   upstream presents a state array
//   bypass           in   pass state through unchanged (final round)
//   state_array      in   [row][column] bytes of the input state
//   next_is_ready    in   downstream accepts the result
//   ready            out  stage can accept a new state
//   valid_out        out  state_array_out holds a complete result
//   state_array_out  out  [row][column] bytes of the result
interface aes_mixcolumns_if;
    logic                  valid;
    logic                  bypass;
    logic [3:0][3:0][7:0]  state_array;
    logic                  next_is_ready;
    logic                  ready;
    logic                  valid_out;
    logic [3:0][3:0][7:0]  state_array_out;

    modport master (
        output valid, bypass, state_array, next_is_ready,
        input  ready, valid_out, state_array_out
    );

    modport slave (
        input  valid, bypass, state_array, next_is_ready,
        output ready, valid_out, state_array_out
    );
endinterface

// File: rtl/aes_mixcolumns.sv
// rtl/aes_mixcolumns.sv - iterative AES MixColumns stage, one column per cycle
//
// Latches a 4x4 state on acceptance, runs it through one shared GF(2^8)
// column multiplier over four cycles, then holds the result until the
// downstream stage takes it. Bypass keeps the same latency for the final round.
//
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   bus    aes_mixcolumns_if.slave  valid/ready block handshake and state data
module aes_mixcolumns #(
    parameter int STATE_ARRAY_DIMENSION = 4
) (
    input  logic             clk,
    input  logic             reset,
    aes_mixcolumns_if.slave  bus
);

    if (STATE_ARRAY_DIMENSION != 4) begin : g_bad_dimension
        $error("aes_mixcolumns: STATE_ARRAY_DIMENSION must be 4");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            col_q;
    logic                  bypass_reg;
    logic [3:0][3:0][7:0]  in_reg;
    logic [3:0][3:0][7:0]  out_reg;
    logic [3:0][7:0]       col_in;
    logic [3:0][7:0]       col_out;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; handshake outputs come from registered state only
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.valid)         state_d = RUNNING;
            RUNNING: if (col_q == 2'd3)     state_d = DONE;
            DONE:    if (bus.next_is_ready) state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    assign bus.ready           = (state_q == IDLE);
    assign bus.valid_out       = (state_q == DONE);
    assign bus.state_array_out = out_reg;

    // Shared column multiplier on the column selected by col_q
    always_comb begin
        col_in  = '0;
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            col_in[r] = in_reg[r][col_q];
        end
        if (bypass_reg) begin
            col_out = col_in;
        end else begin
            col_out[0] = xtime(col_in[0]) ^ xtime(col_in[1]) ^ col_in[1] ^ col_in[2] ^ col_in[3];
            col_out[1] = col_in[0] ^ xtime(col_in[1]) ^ xtime(col_in[2]) ^ col_in[2] ^ col_in[3];
            col_out[2] = col_in[0] ^ col_in[1] ^ xtime(col_in[2]) ^ xtime(col_in[3]) ^ col_in[3];
            col_out[3] = xtime(col_in[0]) ^ col_in[0] ^ col_in[1] ^ col_in[2] ^ xtime(col_in[3]);
        end
    end

    // Datapath: capture on acceptance, write one output column per RUNNING cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= 2'd0;
            bypass_reg <= 1'b0;
            in_reg     <= '0;
            out_reg    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid) begin
                        in_reg     <= bus.state_array;
                        bypass_reg <= bus.bypass;
                        col_q      <= 2'd0;
                    end
                end
                RUNNING: begin
                    for (int r = 0; r < 4; r++) begin
                        out_reg[r][col_q] <= col_out[r];
                    end
                    // Wraps to 0 after the last column, ready for the next block
                    col_q <= col_q + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mixcolumns.sv
// tb/tb_aes_mixcolumns.sv - self-checking bench for aes_mixcolumns
module tb_aes_mixcolumns;

    typedef logic [3:0][3:0][7:0] st_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aes_mixcolumns_if bus ();

    aes_mixcolumns #(.STATE_ARRAY_DIMENSION(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // GF(2^8) product: carry-less multiply then reduce by x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int i = 14; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] coef(input int r, input int k);
        case ((k - r + 4) % 4)
            0:       return 8'h02;
            1:       return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic st_t mix(input st_t a, input logic byp);
        st_t b;
        b = '0;
        if (byp) return a;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int k = 0; k < 4; k++)
                    b[r][c] = b[r][c] ^ gmul(coef(r, k), a[k][c]);
        return b;
    endfunction

    // Build a state from four columns, each given as {row0,row1,row2,row3}
    function automatic st_t mk(input logic [31:0] c0, input logic [31:0] c1,
                               input logic [31:0] c2, input logic [31:0] c3);
        st_t s;
        logic [31:0] cw [4];
        cw[0] = c0; cw[1] = c1; cw[2] = c2; cw[3] = c3;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = cw[c][31 - 8*r -: 8];
        return s;
    endfunction

    function automatic st_t rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural model: phase 0 idle, 1..4 writing columns 0..3, 5 holding result
    int   phase    = 0;
    int   cyc      = 0;
    st_t  acc_full = '0;
    st_t  exp_out  = '0;
    int   acc_cyc [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            phase   <= 0;
            exp_out <= '0;
        end else begin
            case (phase)
                0: if (bus.valid) begin
                    phase    <= 1;
                    acc_full <= mix(bus.state_array, bus.bypass);
                    acc_cyc.push_back(cyc);
                end
                1, 2, 3, 4: begin
                    for (int r = 0; r < 4; r++)
                        exp_out[r][phase-1] <= acc_full[r][phase-1];
                    phase <= phase + 1;
                end
                default: if (bus.next_is_ready) phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ready",     bus.ready,           (phase == 0));
            check("cyc_valid_out", bus.valid_out,       (phase == 5));
            check("cyc_out",       bus.state_array_out, exp_out);
        end
    end

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (!bus.ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check({name, "_ready_wait"}, bus.ready, 1'b1);
    endtask

    task automatic run_block(input st_t s, input logic byp, input logic nir,
                             input st_t exp, input string name);
        int w;
        wait_ready(name);
        bus.valid         = 1'b1;
        bus.state_array   = s;
        bus.bypass        = byp;
        bus.next_is_ready = nir;
        @(posedge clk); #1;
        bus.valid       = 1'b0;
        bus.state_array = rnd_state();
        bus.bypass      = ~byp;
        w = 0;
        while (!bus.valid_out && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check({name, "_latency"}, 128'(w), 128'(4));
        check({name, "_result"}, bus.state_array_out, exp);
    endtask

    st_t v1, o1, v2, o2, hold;
    int  n0, w;

    initial begin
        v1 = mk(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c);
        o1 = mk(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8);
        v2 = mk(32'hc6c6c6c6, 32'hd4d4d4d5, 32'h0, 32'h0);
        o2 = mk(32'hc6c6c6c6, 32'hd5d5d7d6, 32'h0, 32'h0);

        bus.valid         = 1'b0;
        bus.bypass        = 1'b0;
        bus.next_is_ready = 1'b0;
        bus.state_array   = '0;
        reset             = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        check("model_vec1",   mix(v1, 1'b0), o1);
        check("model_vec2",   mix(v2, 1'b0), o2);
        check("model_bypass", mix(v1, 1'b1), v1);
        check("model_gmul",   128'(gmul(8'h57, 8'h13)), 128'(8'hfe));

        check("rst_ready",     bus.ready, 1'b1);
        check("rst_valid_out", bus.valid_out, 1'b0);
        check("rst_out",       bus.state_array_out, 128'h0);
        reset = 1'b0;

        run_block(v1, 1'b0, 1'b1, o1, "vec1");
        run_block(v2, 1'b0, 1'b1, o2, "vec2");
        run_block(v1, 1'b1, 1'b1, v1, "bypass");

        // Back-pressure in DONE while upstream keeps changing its inputs
        run_block(v2, 1'b0, 1'b0, o2, "stall");
        hold = bus.state_array_out;
        repeat (10) begin
            bus.state_array = rnd_state();
            bus.valid       = ~bus.valid;
            @(posedge clk); #1;
            check("stall_stable",    bus.state_array_out, hold);
            check("stall_ready",     bus.ready, 1'b0);
            check("stall_valid_out", bus.valid_out, 1'b1);
        end
        bus.valid         = 1'b0;
        bus.next_is_ready = 1'b1;
        @(posedge clk); #1;
        check("release_ready",     bus.ready, 1'b1);
        check("release_valid_out", bus.valid_out, 1'b0);

        // Reset while column 2 is being computed
        wait_ready("rst_mid");
        bus.valid       = 1'b1;
        bus.state_array = v1;
        bus.bypass      = 1'b0;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ready",     bus.ready, 1'b1);
        check("rst_mid_valid_out", bus.valid_out, 1'b0);
        check("rst_mid_out",       bus.state_array_out, 128'h0);
        reset = 1'b0;
        run_block(v1, 1'b0, 1'b1, o1, "after_rst");

        // Back-to-back blocks with valid held high
        wait_ready("b2b");
        n0                = acc_cyc.size();
        bus.valid         = 1'b1;
        bus.state_array   = v1;
        bus.bypass        = 1'b0;
        bus.next_is_ready = 1'b1;
        @(posedge clk); #1;
        bus.state_array = v2;
        w = 0;
        while (acc_cyc.size() < n0 + 2 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        bus.valid = 1'b0;
        check("b2b_two_accepts", 128'(acc_cyc.size() - n0), 128'(2));
        if (acc_cyc.size() >= n0 + 2)
            check("b2b_spacing", 128'(acc_cyc[n0+1] - acc_cyc[n0]), 128'(6));
        w = 0;
        while (!bus.valid_out && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("b2b_second_result", bus.state_array_out, o2);

        // Randomized traffic, occasional reset, checked every cycle by the model
        repeat (600) begin
            @(posedge clk); #1;
            bus.valid         = 1'($urandom_range(0, 1));
            bus.bypass        = ($urandom_range(0, 3) == 0);
            bus.next_is_ready = ($urandom_range(0, 3) != 0);
            bus.state_array   = rnd_state();
            reset             = ($urandom_range(0, 99) == 0);
        end
        reset     = 1'b0;
        bus.valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_mixcolumns.md
# aes_mixcolumns

Iterative AES MixColumns stage that sits between ShiftRows and AddRoundKey in the round datapath, taking a 4x4 byte state array and producing its MixColumns transform. It uses the same valid/ready block handshake as the SubBytes stage, so stages chain directly. It latches the input state on acceptance and processes one column per cycle through a single shared GF(2^8) column multiplier. A `bypass` input skips the transform for the AES final round, which has no MixColumns, while keeping the same latency.

## Interface
- `STATE_ARRAY_DIMENSION`, default 4: state array side length. Only 4 is legal; elaboration fails (`$error`) for any other value.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `valid`  in  1: upstream has a state array on `state_array`.
- `next_is_ready`  in  1: downstream accepts the result.
- `bypass`  in  1: sampled at acceptance; 1 passes the state through unchanged (final round).
- `state_array`  in  8 x [4][4]: input state, indexed `[row][column]`.
- `state_array_out`  out  8 x [4][4]: registered result, indexed `[row][column]`.
- `ready`  out  1: block can accept a new state.
- `valid_out`  out  1: `state_array_out` holds a complete result.

## Operation
- FSM states: IDLE, RUNNING, DONE.
  - `ready` = (state == IDLE).
  - `valid_out` = (state == DONE).
  - Both are decoded from registered state, with no combinational path from `valid` or `next_is_ready`.
- IDLE:
  - If `valid`=1, latch `state_array` into `in_reg`, latch `bypass` into `bypass_reg`, set column counter `col` to 0, and go to RUNNING.
  - Otherwise stay in IDLE.
- RUNNING, each cycle:
  - Compute column `col` from `in_reg` rows 0..3.
  - Write the result into `out_reg[0..3][col]`. Other columns are untouched.
  - If `col`==3, go to DONE. Otherwise increment `col`.
- DONE:
  - `out_reg` is held stable.
  - If `next_is_ready`=1, go to IDLE. Otherwise stay in DONE.
- Column math, with a0..a3 = rows 0..3:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00). 2a = xtime(a); 3a = xtime(a)^a.
  - All arithmetic is 8-bit XOR only. No carries, no widening.
- Bypass: when `bypass_reg`=1, b_i = a_i. The FSM sequence and latency are identical.
- `state_array` and `bypass` are ignored outside IDLE. Upstream may change them freely after acceptance.
- `next_is_ready` is ignored outside DONE.
- An unreachable FSM encoding goes to IDLE.

## Timing
- Reset values:
  - state = IDLE, so `ready`=1 and `valid_out`=0.
  - `col`=0, `bypass_reg`=0.
  - All `out_reg` and `in_reg` bytes = 8'h00.
  - `state_array_out` = all zero.
- Reset mid-operation (RUNNING or DONE) takes effect at the next edge: back to IDLE with all reset values. The partial result is discarded.
- Latency:
  - Acceptance edge E0 is the edge where state==IDLE and `valid`=1.
  - Columns 0..3 are written at edges E1..E4.
  - `valid_out` rises after E4.
- Leaving DONE:
  - With `next_is_ready`=1 already high, the edge after E4 (E5) moves to IDLE.
  - `ready` is high after E5.
  - The next acceptance is E6 at the earliest. Minimum block period is 6 cycles.
- `ready` stays low from E0 until IDLE is re-entered. `valid` held high during that time does not start a second operation.
- Partial writes: `state_array_out` columns change one per cycle during RUNNING. Consumers sample only while `valid_out`=1.
- Back-pressure: DONE can last any number of cycles. Output is bit-stable throughout.

## Test plan
- Reset, then one block with columns (db,13,53,45), (f2,0a,22,5c), (01,01,01,01), (2d,26,31,4c) and `next_is_ready`=1 -> `valid_out` high exactly 4 cycles after acceptance. Output columns (8e,4d,a1,bc), (9f,dc,58,9d), (01,01,01,01), (4d,7e,bd,f8).
- Columns (c6,c6,c6,c6) and (d4,d4,d4,d5) in columns 0 and 1 -> (c6,c6,c6,c6) and (d5,d5,d7,d6).
- Same input as the first scenario with `bypass`=1 at acceptance -> output equals input byte-for-byte, same 4-cycle latency.
- Hold `next_is_ready`=0 for 10 cycles in DONE while changing `state_array` and toggling `valid` -> output stable, `ready`=0, no new acceptance. Release `next_is_ready` -> IDLE next cycle.
- Assert `reset` during RUNNING at col=2 -> next cycle `ready`=1, `valid_out`=0, all outputs 8'h00. A subsequent block produces correct results.
- Two back-to-back blocks with `valid` held high and `next_is_ready`=1 -> acceptances exactly 6 cycles apart, both results correct.
